// File: rtl/c17_fault_sequencer_if.sv
// Mismatch-record handshake between the fault sequencer (master) and its consumer (slave).
interface c17_fault_sequencer_if;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_opcode;
    logic [4:0] res_pattern;
    logic       res_n22;
    logic       res_n23;

    modport master (
        output res_valid,
        output res_opcode,
        output res_pattern,
        output res_n22,
        output res_n23,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_opcode,
        input  res_pattern,
        input  res_n22,
        input  res_n23,
        output res_ready
    );
endinterface

// File: rtl/c17_fault_sequencer.sv
// Exhaustive stuck-at fault campaign driver for an ISCAS c17 block.
// First captures the fault-free response for all 32 input patterns, then replays every
// pattern under each of the 22 table faults and emits a record for every output mismatch.
module c17_fault_sequencer (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [4:0]                    dut_in,
    output logic [5:0]                    dut_opcode,
    input  logic                          dut_n22,
    input  logic                          dut_n23,
    c17_fault_sequencer_if.master         res,
    output logic [21:0]                   detected,
    output logic [9:0]                    mism_cnt,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned NumPatterns = 32;
    localparam logic [4:0]  LastPattern = 5'd31;
    localparam logic [4:0]  LastFault   = 5'd21;

    typedef enum logic [2:0] {
        StIdle,
        StGolden,
        StFault,
        StDrain,
        StDone
    } state_e;

    // Fixed fault list; entry index is also the bit position in detected.
    function automatic logic [5:0] fault_opcode(input logic [4:0] idx);
        logic [5:0] op;
        case (idx)
            5'd0:    op = 6'h03;
            5'd1:    op = 6'h11;
            5'd2:    op = 6'h13;
            5'd3:    op = 6'h07;
            5'd4:    op = 6'h06;
            5'd5:    op = 6'h0D;
            5'd6:    op = 6'h05;
            5'd7:    op = 6'h0F;
            5'd8:    op = 6'h15;
            5'd9:    op = 6'h29;
            5'd10:   op = 6'h21;
            5'd11:   op = 6'h20;
            5'd12:   op = 6'h27;
            5'd13:   op = 6'h2B;
            5'd14:   op = 6'h2D;
            5'd15:   op = 6'h2C;
            5'd16:   op = 6'h2F;
            5'd17:   op = 6'h2E;
            5'd18:   op = 6'h17;
            5'd19:   op = 6'h16;
            5'd20:   op = 6'h1D;
            5'd21:   op = 6'h1F;
            default: op = 6'h00;
        endcase
        return op;
    endfunction

    state_e      state_q;
    logic [4:0]  pattern_q;
    logic [4:0]  fault_q;
    logic [5:0]  opcode_q;
    logic        valid_q;
    logic [5:0]  rec_opcode_q;
    logic [4:0]  rec_pattern_q;
    logic        rec_n22_q;
    logic        rec_n23_q;
    logic [21:0] detected_q;
    logic [9:0]  mism_cnt_q;
    logic        busy_q;
    logic        done_q;

    // Fault-free response per pattern, {n22, n23}; always rewritten in GOLDEN before use.
    logic [1:0]  golden_q [NumPatterns];

    logic [1:0]  obs;
    logic        slot_free;
    logic        mismatch;

    // Compare/advance qualifiers for the current cycle.
    always_comb begin
        obs       = {dut_n22, dut_n23};
        slot_free = !valid_q || res.res_ready;
        mismatch  = (obs != golden_q[pattern_q]);
    end

    // Golden capture: the pattern applied last edge has settled by this edge.
    always_ff @(posedge clk) begin
        if (state_q == StGolden) begin
            golden_q[pattern_q] <= obs;
        end
    end

    // Campaign FSM with registered stimulus, record and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pattern_q     <= 5'd0;
            fault_q       <= 5'd0;
            opcode_q      <= 6'd0;
            valid_q       <= 1'b0;
            rec_opcode_q  <= 6'd0;
            rec_pattern_q <= 5'd0;
            rec_n22_q     <= 1'b0;
            rec_n23_q     <= 1'b0;
            detected_q    <= 22'd0;
            mism_cnt_q    <= 10'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Consumer takes the record; a new load below takes priority.
            if (res.res_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StGolden;
                        pattern_q  <= 5'd0;
                        fault_q    <= 5'd0;
                        opcode_q   <= 6'd0;
                        detected_q <= 22'd0;
                        mism_cnt_q <= 10'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end

                StGolden: begin
                    if (pattern_q == LastPattern) begin
                        state_q   <= StFault;
                        pattern_q <= 5'd0;
                        fault_q   <= 5'd0;
                        opcode_q  <= fault_opcode(5'd0);
                    end else begin
                        pattern_q <= pattern_q + 5'd1;
                    end
                end

                StFault: begin
                    // Stall everything while an unaccepted record occupies the slot.
                    if (slot_free) begin
                        if (mismatch) begin
                            valid_q             <= 1'b1;
                            rec_opcode_q        <= opcode_q;
                            rec_pattern_q       <= pattern_q;
                            rec_n22_q           <= dut_n22;
                            rec_n23_q           <= dut_n23;
                            detected_q[fault_q] <= 1'b1;
                            mism_cnt_q          <= mism_cnt_q + 10'd1;
                        end
                        if (pattern_q == LastPattern) begin
                            pattern_q <= 5'd0;
                            if (fault_q == LastFault) begin
                                state_q  <= StDrain;
                                opcode_q <= 6'd0;
                            end else begin
                                fault_q  <= fault_q + 5'd1;
                                opcode_q <= fault_opcode(fault_q + 5'd1);
                            end
                        end else begin
                            pattern_q <= pattern_q + 5'd1;
                        end
                    end
                end

                StDrain: begin
                    // Finish once the last record is gone (or leaves on this edge).
                    if (slot_free) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in          = pattern_q;
    assign dut_opcode      = opcode_q;
    assign res.res_valid   = valid_q;
    assign res.res_opcode  = rec_opcode_q;
    assign res.res_pattern = rec_pattern_q;
    assign res.res_n22     = rec_n22_q;
    assign res.res_n23     = rec_n23_q;
    assign detected        = detected_q;
    assign mism_cnt        = mism_cnt_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_c17_fault_sequencer.sv
// Randomized self-checking bench for c17_fault_sequencer with a fault-injectable c17 model.
module tb_c17_fault_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  dut_in;
    logic [5:0]  dut_opcode;
    logic        dut_n22;
    logic        dut_n23;
    logic [21:0] detected;
    logic [9:0]  mism_cnt;
    logic        busy;
    logic        done;

    c17_fault_sequencer_if res_if ();

    c17_fault_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dut_in     (dut_in),
        .dut_opcode (dut_opcode),
        .dut_n22    (dut_n22),
        .dut_n23    (dut_n23),
        .res        (res_if.master),
        .detected   (detected),
        .mism_cnt   (mism_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] FaultOps [22] = '{
        6'h03, 6'h11, 6'h13, 6'h07, 6'h06, 6'h0D, 6'h05, 6'h0F, 6'h15, 6'h29, 6'h21,
        6'h20, 6'h27, 6'h2B, 6'h2D, 6'h2C, 6'h2F, 6'h2E, 6'h17, 6'h16, 6'h1D, 6'h1F
    };

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] pat;
        logic       n22;
        logic       n23;
    } rec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          mode  = 0;   // 0 real c17, 1 always fault-free, 2 N22 inverted for opcode 11h
    rec_t        exp_q [$];
    int          exp_cnt;
    logic [21:0] exp_det;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Opcode = {line id, stuck value}; line id is the c17 net number, branches use 8,9,14,15,20,21.
    function automatic logic flt(input logic [5:0] op, input int id, input logic v);
        return (op != 6'd0 && int'(op[5:1]) == id) ? op[0] : v;
    endfunction

    function automatic logic [1:0] c17(input logic [4:0] pi, input logic [5:0] op);
        logic n1, n2, n3, n6, n7, n3a, n3b, n10, n11, n11a, n11b, n16, n19, n16a, n16b;
        logic n22, n23;
        n1   = flt(op, 1, pi[0]);
        n2   = flt(op, 2, pi[1]);
        n3   = flt(op, 3, pi[2]);
        n6   = flt(op, 6, pi[3]);
        n7   = flt(op, 7, pi[4]);
        n3a  = flt(op, 8, n3);
        n3b  = flt(op, 9, n3);
        n10  = flt(op, 10, ~(n1 & n3a));
        n11  = flt(op, 11, ~(n3b & n6));
        n11a = flt(op, 14, n11);
        n11b = flt(op, 15, n11);
        n16  = flt(op, 16, ~(n2 & n11a));
        n19  = flt(op, 19, ~(n11b & n7));
        n16a = flt(op, 20, n16);
        n16b = flt(op, 21, n16);
        n22  = flt(op, 22, ~(n10 & n16a));
        n23  = flt(op, 23, ~(n16b & n19));
        return {n22, n23};
    endfunction

    function automatic logic [1:0] dut_model(input int md, input logic [4:0] pi,
                                             input logic [5:0] op);
        logic [1:0] o;
        case (md)
            0:       o = c17(pi, op);
            1:       o = c17(pi, 6'd0);
            default: begin
                o = c17(pi, 6'd0);
                if (op == 6'h11) o[1] = ~o[1];
            end
        endcase
        return o;
    endfunction

    always_comb begin
        {dut_n22, dut_n23} = dut_model(mode, dut_in, dut_opcode);
    end

    // Expected record stream: every (fault, pattern) whose response differs from fault-free.
    task automatic build_expected(input int md);
        logic [1:0] g;
        logic [1:0] o;
        rec_t       r;
        exp_q.delete();
        exp_cnt = 0;
        exp_det = '0;
        for (int f = 0; f < 22; f++) begin
            for (int p = 0; p < 32; p++) begin
                g = dut_model(md, 5'(p), 6'd0);
                o = dut_model(md, 5'(p), FaultOps[f]);
                if (o != g) begin
                    r = '{op: FaultOps[f], pat: 5'(p), n22: o[1], n23: o[0]};
                    exp_q.push_back(r);
                    exp_cnt++;
                    exp_det[f] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_campaign(input int md, input int ready_pct, input bit do_bp,
                                input int poke_at);
        rec_t        r;
        rec_t        held;
        int          cyc;
        int          bp_left;
        bit          bp_done;
        bit          frozen_ok;
        logic [4:0]  held_in;
        logic [5:0]  held_op;
        logic [9:0]  held_cnt;
        logic        rdy;
        mode = md;
        build_expected(md);
        bp_left = 0;
        bp_done = 1'b0;
        frozen_ok = 1'b1;
        held = '0;
        held_in = '0;
        held_op = '0;
        held_cnt = '0;
        @(negedge clk);
        start = 1'b1;
        res_if.res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_det_clr", 32'(detected), 32'd0);
        check_eq("start_cnt_clr", 32'(mism_cnt), 32'd0);
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_done_low", 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (cyc == 32) begin
                check_eq("golden0", 32'(u_dut.golden_q[0]), 32'(dut_model(md, 5'd0, 6'd0)));
                check_eq("golden31", 32'(u_dut.golden_q[31]), 32'(dut_model(md, 5'd31, 6'd0)));
            end
            start = (cyc == poke_at);
            if (bp_left > 0) begin
                rdy = 1'b0;
                if ({res_if.res_opcode, res_if.res_pattern, res_if.res_n22, res_if.res_n23}
                        != held || !res_if.res_valid || dut_in != held_in
                        || dut_opcode != held_op || mism_cnt != held_cnt) begin
                    frozen_ok = 1'b0;
                end
                bp_left--;
                if (bp_left == 0) check_eq("bp_frozen", 32'(frozen_ok), 32'd1);
            end else if (do_bp && !bp_done && res_if.res_valid) begin
                rdy = 1'b0;
                bp_done = 1'b1;
                bp_left = 10;
                held = {res_if.res_opcode, res_if.res_pattern, res_if.res_n22, res_if.res_n23};
                held_in = dut_in;
                held_op = dut_opcode;
                held_cnt = mism_cnt;
            end else begin
                rdy = ($urandom_range(99) < 32'(ready_pct));
            end
            res_if.res_ready = rdy;
            if (res_if.res_valid && rdy) begin
                check_eq("rec_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check_eq("record",
                             32'({res_if.res_opcode, res_if.res_pattern, res_if.res_n22,
                                  res_if.res_n23}), 32'(r));
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        res_if.res_ready = 1'b1;
        check_eq("done_reached", 32'(done), 32'd1);
        if (ready_pct == 100 && !do_bp && poke_at < 0) begin
            check_eq("latency_le_738", 32'(cyc <= 738), 32'd1);
        end
        if (do_bp) check_eq("bp_happened", 32'(bp_done), 32'(exp_cnt != 0));
        check_eq("records_left", 32'(exp_q.size()), 32'd0);
        check_eq("mism_cnt", 32'(mism_cnt), 32'(exp_cnt));
        check_eq("detected", 32'(detected), 32'(exp_det));
        check_eq("done_valid_low", 32'(res_if.res_valid), 32'd0);
        check_eq("done_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("hold_cnt", 32'(mism_cnt), 32'(exp_cnt));
        check_eq("hold_det", 32'(detected), 32'(exp_det));
        check_eq("hold_done", 32'(done), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in"}, 32'(dut_in), 32'd0);
        check_eq({tag, "_op"}, 32'(dut_opcode), 32'd0);
        check_eq({tag, "_valid"}, 32'(res_if.res_valid), 32'd0);
        check_eq({tag, "_fields"}, 32'({res_if.res_opcode, res_if.res_pattern, res_if.res_n22,
                                        res_if.res_n23}), 32'd0);
        check_eq({tag, "_det"}, 32'(detected), 32'd0);
        check_eq({tag, "_cnt"}, 32'(mism_cnt), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic reset_mid_fault();
        int  t;
        bit  found;
        mode = 0;
        res_if.res_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        t = 0;
        while (!found && t < 2000) begin
            if (dut_opcode == FaultOps[5] && busy) found = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        check_eq("reach_f5", 32'(found), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        check_eq("midrst_stay_idle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        res_if.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        run_campaign(0, 100, 1'b0, -1);
        run_campaign(1, 100, 1'b0, -1);
        check_eq("m1_no_records", 32'(mism_cnt), 32'd0);
        run_campaign(2, 100, 1'b1, -1);
        check_eq("m2_det", 32'(detected), 32'h000002);
        check_eq("m2_cnt", 32'(mism_cnt), 32'd32);
        run_campaign(0, 60, 1'b0, 300);
        run_campaign(2, 40, 1'b0, 100);
        reset_mid_fault();
        run_campaign(0, 100, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
